keypad_scanner: RTL and testbench

Multiplexed 4x4 hex keypad scanner: the input-side counterpart to the 7-segment display driver. It strobes keypad columns with an active-low one-hot pattern, samples the row lines, debounces single-key presses over whole scans, and shifts each accepted hex digit into a 16-bit entry register. That register can feed the display driver's `dataIn` directly, so the board has a hex entry/echo path.

---
 rtl/keypad_scanner.sv | 158 +++++++++++++++
 tb/tb_keypad_scanner.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_scanner.sv
// 4x4 hex keypad scanner: strobes columns active-low, samples synchronized rows,
// debounces single presses over whole scans and shifts accepted digits into dataOut.
module keypad_scanner #(
  parameter int SCAN_DIV       = 6250,
  parameter int DEBOUNCE_SCANS = 3
) (
  input  logic        gclock,
  input  logic        greset,
  input  logic [3:0]  KeyRow,
  input  logic        clear,
  output logic [3:0]  KeyCol,
  output logic        keyValid,
  output logic [3:0]  keyCode,
  output logic [15:0] dataOut,
  output logic [1:0]  fsm_state
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_PRESS   = 2'd1,
    S_HELD    = 2'd2,
    S_RELEASE = 2'd3
  } state_e;

  localparam logic [15:0] DIV_LAST = 16'(SCAN_DIV - 1);
  localparam logic [3:0]  DEB_N    = 4'(DEBOUNCE_SCANS);

  logic [3:0]  row_s1_q, row_s2_q;
  logic [15:0] dwell_q;
  logic [1:0]  col_q;
  logic [3:0]  kcol_q;
  logic [15:0] map_q;
  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [3:0]  cand_q, cand_d;
  logic        valid_q;
  logic [3:0]  code_q;
  logic [15:0] data_q;

  logic        sample, scan_end, accept;
  logic [15:0] col_bits, full_map;
  logic        is_none, is_single;
  logic [3:0]  single_idx;

  assign sample   = (dwell_q == DIV_LAST);
  assign scan_end = sample && (col_q == 2'd3);

  // Column c's sample lands on map bits 4*r+c; the last column is merged
  // combinationally so the scan can be judged on its final cycle.
  always_comb begin
    col_bits = '0;
    if (sample) begin
      for (int r = 0; r < 4; r++) begin
        col_bits[{2'(r), col_q}] = ~row_s2_q[r];
      end
    end
    full_map = map_q | col_bits;
  end

  always_comb begin
    single_idx = 4'd0;
    for (int i = 0; i < 16; i++) begin
      if (full_map[i]) single_idx = 4'(i);
    end
    is_none   = (full_map == 16'h0000);
    is_single = !is_none && ((full_map & (full_map - 16'd1)) == 16'h0000);
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cand_d  = cand_q;
    accept  = 1'b0;
    if (scan_end) begin
      case (state_q)
        S_IDLE: begin
          if (is_single) begin
            cand_d  = single_idx;
            cnt_d   = 4'd1;
            state_d = S_PRESS;
          end
        end
        S_PRESS: begin
          if (is_single && single_idx == cand_q) begin
            cnt_d = cnt_q + 4'd1;
            if (cnt_q + 4'd1 == DEB_N) begin
              accept  = 1'b1;
              state_d = S_HELD;
            end
          end else begin
            state_d = S_IDLE;
          end
        end
        S_HELD: begin
          if (is_none) begin
            cnt_d   = 4'd1;
            state_d = S_RELEASE;
          end
        end
        S_RELEASE: begin
          if (is_none) begin
            cnt_d = cnt_q + 4'd1;
            if (cnt_q + 4'd1 == DEB_N) state_d = S_IDLE;
          end else begin
            state_d = S_HELD;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge gclock or posedge greset) begin
    if (greset) begin
      row_s1_q <= 4'b1111;
      row_s2_q <= 4'b1111;
      dwell_q  <= 16'd0;
      col_q    <= 2'd0;
      kcol_q   <= 4'b1110;
      map_q    <= 16'h0000;
      state_q  <= S_IDLE;
      cnt_q    <= 4'd0;
      cand_q   <= 4'd0;
      valid_q  <= 1'b0;
      code_q   <= 4'd0;
      data_q   <= 16'h0000;
    end else begin
      row_s1_q <= KeyRow;
      row_s2_q <= row_s1_q;
      if (sample) begin
        dwell_q <= 16'd0;
        col_q   <= col_q + 2'd1;
        kcol_q  <= {kcol_q[2:0], kcol_q[3]};
        map_q   <= scan_end ? 16'h0000 : full_map;
      end else begin
        dwell_q <= dwell_q + 16'd1;
      end
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cand_q  <= cand_d;
      valid_q <= accept;
      if (accept) code_q <= cand_q;
      // Clear wins over the old contents but keeps a digit accepted on the same edge.
      if (clear) begin
        data_q <= accept ? {12'h000, cand_q} : 16'h0000;
      end else if (accept) begin
        data_q <= {data_q[11:0], cand_q};
      end
    end
  end

  assign KeyCol    = kcol_q;
  assign keyValid  = valid_q;
  assign keyCode   = code_q;
  assign dataOut   = data_q;
  assign fsm_state = state_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: a keypad model drives rows from the strobed column,
// and a scan-level debounce model plus a digit queue predict every output.
module tb_keypad_scanner;

  localparam int SCAN_DIV = 4;
  localparam int DEB      = 3;
  localparam int SCAN_CYC = 4 * SCAN_DIV;

  logic        gclock = 1'b0;
  logic        greset;
  logic        clear;
  logic [3:0]  key_row;
  logic [3:0]  key_col;
  logic        key_valid;
  logic [3:0]  key_code;
  logic [15:0] data_out;
  logic [1:0]  fsm_state;
  logic [15:0] keys;

  int checks   = 0;
  int failures = 0;

  // Scoreboard: every digit accepted since the last clear/reset, oldest first.
  logic [15:0] exp_q[$];
  logic [3:0]  exp_code;

  // Scan-level debounce model: 0 idle, 1 counting a press, 2 held, 3 counting a release.
  int         m_mode;
  int         m_cnt;
  logic [3:0] m_cand;

  keypad_scanner #(
    .SCAN_DIV      (SCAN_DIV),
    .DEBOUNCE_SCANS(DEB)
  ) dut (
    .gclock   (gclock),
    .greset   (greset),
    .KeyRow   (key_row),
    .clear    (clear),
    .KeyCol   (key_col),
    .keyValid (key_valid),
    .keyCode  (key_code),
    .dataOut  (data_out),
    .fsm_state(fsm_state)
  );

  always #5 gclock = ~gclock;

  // Physical keypad: a pressed key pulls its row low while its column is strobed.
  always_comb begin
    key_row = 4'hF;
    for (int c = 0; c < 4; c++) begin
      if (!key_col[c]) begin
        for (int r = 0; r < 4; r++) begin
          if (keys[4*r+c]) key_row[r] = 1'b0;
        end
      end
    end
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] exp_data();
    logic [15:0] r;
    int n;
    r = 16'h0000;
    n = exp_q.size();
    for (int i = (n > 4) ? n - 4 : 0; i < n; i++) r = {r[11:0], exp_q[i][3:0]};
    return r;
  endfunction

  function automatic logic model_scan(input logic [15:0] map);
    int n;
    logic [3:0] k;
    logic acc;
    n   = $countones(map);
    k   = 4'd0;
    acc = 1'b0;
    for (int b = 0; b < 16; b++) if (map[b]) k = 4'(b);
    case (m_mode)
      0: if (n == 1) begin m_cand = k; m_cnt = 1; m_mode = 1; end
      1: begin
        if (n == 1 && k == m_cand) begin
          m_cnt++;
          if (m_cnt == DEB) begin acc = 1'b1; m_mode = 2; end
        end else m_mode = 0;
      end
      2: if (n == 0) begin m_cnt = 1; m_mode = 3; end
      default: begin
        if (n == 0) begin
          m_cnt++;
          if (m_cnt == DEB) m_mode = 0;
        end else m_mode = 2;
      end
    endcase
    return acc;
  endfunction

  task automatic model_reset();
    exp_q.delete();
    exp_code = 4'd0;
    m_mode   = 0;
    m_cnt    = 0;
    m_cand   = 4'd0;
  endtask

  task automatic do_reset();
    keys   = 16'h0000;
    clear  = 1'b0;
    greset = 1'b1;
    model_reset();
    #12;
    @(negedge gclock);
    greset = 1'b0;
  endtask

  // One full scan with a steady key map; clr_at (1..16) pulses clear before that edge.
  task automatic run_scan(input logic [15:0] map, input int clr_at);
    logic acc;
    logic [3:0] one;
    keys = map;
    acc  = 1'b0;
    for (int i = 1; i <= SCAN_CYC; i++) begin
      clear = (i == clr_at);
      @(posedge gclock);
      #1;
      clear = 1'b0;
      if (i == SCAN_CYC) acc = model_scan(map);
      if (i == clr_at) exp_q.delete();
      if (acc) begin
        exp_q.push_back(16'(m_cand));
        exp_code = m_cand;
      end
      one = 4'b0001 << ((i % SCAN_CYC) / SCAN_DIV);
      check("KeyCol", {12'h0, key_col}, {12'h0, ~one});
      check("keyValid", {15'h0, key_valid}, {15'h0, acc});
      check("keyCode", {12'h0, key_code}, {12'h0, exp_code});
      check("dataOut", data_out, exp_data());
    end
  endtask

  task automatic run_scans(input logic [15:0] map, input int n);
    for (int s = 0; s < n; s++) run_scan(map, 0);
  endtask

  task automatic enter_key(input int code, input int hold, input int rel);
    run_scans(16'h0001 << code, hold);
    run_scans(16'h0000, rel);
  endtask

  initial begin
    do_reset();
    check("reset_KeyCol", {12'h0, key_col}, 16'h000E);
    check("reset_keyValid", {15'h0, key_valid}, 16'h0000);
    check("reset_keyCode", {12'h0, key_code}, 16'h0000);
    check("reset_dataOut", data_out, 16'h0000);
    run_scans(16'h0000, 1);

    // Single press of key (r=2,c=1) held for six scans
    run_scans(16'h0200, 6);
    check("single_code", {12'h0, key_code}, 16'h0009);
    check("single_data", data_out, 16'h0009);
    run_scans(16'h0000, 4);

    // Digit sequence 1..5
    for (int d = 1; d <= 5; d++) enter_key(d, 4, 4);
    check("seq_data", data_out, 16'h2345);
    check("seq_code", {12'h0, key_code}, 16'h0005);

    // Press bounce, then release glitch after an accept
    run_scans(16'h0040, 2);
    run_scans(16'h0000, 1);
    run_scans(16'h0040, 2);
    run_scans(16'h0000, 4);
    run_scans(16'h0040, 3);
    run_scans(16'h0000, 1);
    run_scans(16'h0040, 3);
    run_scans(16'h0000, 4);

    // Two keys together, then one released
    run_scans(16'h0021, 5);
    run_scans(16'h0001, 3);
    check("multi_code", {12'h0, key_code}, 16'h0000);
    run_scans(16'h0000, 4);

    // Build 0xABCD, then clear on the accept edge of key 7, then a lone clear
    for (int d = 10; d <= 13; d++) enter_key(d, 3, 3);
    check("abcd_data", data_out, 16'hABCD);
    run_scans(16'h0080, 2);
    run_scan(16'h0080, SCAN_CYC);
    check("clear_accept_data", data_out, 16'h0007);
    run_scans(16'h0000, 3);
    run_scan(16'h0000, 5);
    check("clear_alone_data", data_out, 16'h0000);
    check("clear_alone_code", {12'h0, key_code}, 16'h0007);
    enter_key(3, 3, 3);

    // Asynchronous reset while column 2 is strobed and key 9 is held
    keys = 16'h0200;
    repeat (2 * SCAN_DIV + 1) @(posedge gclock);
    #1;
    check("pre_reset_KeyCol", {12'h0, key_col}, 16'h000B);
    #3;
    greset = 1'b1;
    #1;
    check("midreset_KeyCol", {12'h0, key_col}, 16'h000E);
    check("midreset_dataOut", data_out, 16'h0000);
    check("midreset_keyValid", {15'h0, key_valid}, 16'h0000);
    model_reset();
    @(negedge gclock);
    greset = 1'b0;
    run_scans(16'h0200, 4);
    run_scans(16'h0000, 3);

    // Randomized key activity with occasional clears
    for (int s = 0; s < 60; s++) begin
      int kind;
      int len;
      logic [15:0] map;
      kind = $urandom_range(0, 9);
      len  = $urandom_range(1, 4);
      if (kind < 4) map = 16'h0000;
      else if (kind < 9) map = 16'h0001 << (4 * $urandom_range(0, 3) + $urandom_range(0, 1));
      else map = 16'h0003 << $urandom_range(0, 14);
      for (int j = 0; j < len; j++) begin
        run_scan(map, ($urandom_range(0, 7) == 0) ? $urandom_range(1, SCAN_CYC) : 0);
      end
    end
    run_scans(16'h0000, 3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
